// File: rtl/ifb_pkg.sv
// Shared definitions for the instruction fetch buffer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Holds the fetch FSM state encoding, the NOP word presented when the queue
// is empty, and the sequential fetch address step.
package ifb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,  // waiting for start
      FETCH = 2'd1,  // no request outstanding, may issue one
      WAIT  = 2'd2,  // one request outstanding, its data will be queued
      DROP  = 2'd3   // one request outstanding, its data will be discarded
   } ifbState_t;

   localparam logic [31:0] NOP    = 32'h0000_0000;
   localparam int unsigned PC_INC = 4;

endpackage

// File: rtl/ifb_fifo.sv
// Synchronous FIFO with single-cycle flush, used as the prefetch queue.
// Latency: a push is visible at popData/empty one cycle later.
// Backpressure: push ignored when full, pop ignored when empty; flush wins over both.
//
// Ports:
//   clock, reset      - clock and asynchronous active-high reset
//   flush             - empties the queue at the next edge
//   push, pushData    - write one entry
//   pop               - drop the head entry
//   popData           - head entry (meaningful only while !empty)
//   empty, full       - occupancy flags
module ifb_fifo #(
   parameter int WIDTH = 48,
   parameter int DEPTH = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             flush,
   input  logic             push,
   input  logic [WIDTH-1:0] pushData,
   input  logic             pop,
   output logic [WIDTH-1:0] popData,
   output logic             empty,
   output logic             full
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
   localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    rdPtr;
   logic [AW-1:0]    wrPtr;
   logic [AW:0]      count;
   logic             doPush;
   logic             doPop;

   assign empty   = (count == '0);
   assign full    = (count == FULL_CNT);
   assign doPush  = push && !full;
   assign doPop   = pop && !empty;
   assign popData = mem[rdPtr];

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rdPtr <= '0;
         wrPtr <= '0;
         count <= '0;
      end else if (flush) begin
         rdPtr <= '0;
         wrPtr <= '0;
         count <= '0;
      end else begin
         if (doPush) wrPtr <= wrPtr + PTR_ONE;
         if (doPop)  rdPtr <= rdPtr + PTR_ONE;
         case ({doPush, doPop})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase
      end
   end

   // Storage needs no reset: entries are only read while counted valid.
   always_ff @(posedge clock) begin
      if (doPush && !flush) mem[wrPtr] <= pushData;
   end

endmodule

// File: rtl/instr_fetch_buffer.sv
// Instruction prefetch: issues sequential word fetches and queues returned words.
// Latency: ack to instr_valid is 1 cycle on an empty queue (0 with IFB_BYPASS_EN).
// Backpressure: at most DEPTH words queued-or-outstanding; fetching pauses while full.
//
// Ports:
//   clock, reset                 - clock and asynchronous active-high reset
//   start                        - level, leaves IDLE and begins fetching
//   imem_req, imem_addr          - memory read request, held until imem_ack
//   imem_ack, imem_rdata         - one-cycle response with the fetched word
//   redirect, redirect_pc        - flush the queue and restart at a new address
//   instr_valid, instr_ready     - valid/ready handshake for the queue head
//   instr_out, instr_pc          - head word and its address (zero when not valid)
//
// Build option: define IFB_BYPASS_EN to hand an acked word straight to the
// consumer in the ack cycle when the queue is empty and instr_ready is high.
module instr_fetch_buffer
   import ifb_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int PC_W  = 16
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            start,
   output logic            imem_req,
   output logic [PC_W-1:0] imem_addr,
   input  logic            imem_ack,
   input  logic [31:0]     imem_rdata,
   input  logic            redirect,
   input  logic [PC_W-1:0] redirect_pc,
   output logic            instr_valid,
   input  logic            instr_ready,
   output logic [31:0]     instr_out,
   output logic [PC_W-1:0] instr_pc
);

   localparam int EW = PC_W + 32;
   localparam logic [PC_W-1:0] ALIGN_MASK = ~PC_W'(3);
   localparam logic [PC_W-1:0] PC_STEP    = PC_W'(PC_INC);

   ifbState_t       state;
   ifbState_t       nextState;
   logic [PC_W-1:0] fetchPc;
   logic [PC_W-1:0] nextFetchPc;
   logic [PC_W-1:0] reqAddr;     // address of the outstanding request
   logic [PC_W-1:0] nextReqAddr;
   logic [PC_W-1:0] redirectPc;
   logic            issue;
   logic            pushEn;
   logic            popEn;
   logic            fifoEmpty;
   logic            fifoFull;
   logic [EW-1:0]   headData;
   logic            bypass;

   assign redirectPc = redirect_pc & ALIGN_MASK;

`ifdef IFB_BYPASS_EN
   assign bypass = (state == WAIT) && imem_ack && !redirect && fifoEmpty && instr_ready;
`else
   assign bypass = 1'b0;
`endif

   // A flush in the same cycle discards the pop anyway; gating keeps intent clear.
   assign popEn = !fifoEmpty && instr_ready && !redirect;

   ifb_fifo #(
      .WIDTH (EW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clock    (clock),
      .reset    (reset),
      .flush    (redirect),
      .push     (pushEn),
      .pushData ({reqAddr, imem_rdata}),
      .pop      (popEn),
      .popData  (headData),
      .empty    (fifoEmpty),
      .full     (fifoFull)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         fetchPc <= '0;
         reqAddr <= '0;
      end else begin
         state   <= nextState;
         fetchPc <= nextFetchPc;
         reqAddr <= nextReqAddr;
      end
   end

   always_comb begin
      nextState   = state;
      nextFetchPc = fetchPc;
      nextReqAddr = reqAddr;
      issue       = 1'b0;
      pushEn      = 1'b0;
      case (state)
         IDLE: begin
            if (redirect) nextFetchPc = redirectPc;
            if (start)    nextState   = FETCH;
         end
         FETCH: begin
            // No request is outstanding here, so the queue alone bounds the
            // in-flight total. A redirect suppresses the issue so the request
            // never goes out with a stale address.
            if (redirect) begin
               nextFetchPc = redirectPc;
            end else if (!fifoFull) begin
               issue       = 1'b1;
               nextReqAddr = fetchPc;
               nextState   = WAIT;
            end
         end
         WAIT: begin
            if (redirect) begin
               nextFetchPc = redirectPc;
               nextState   = imem_ack ? FETCH : DROP;
            end else if (imem_ack) begin
               pushEn      = !bypass;
               nextFetchPc = reqAddr + PC_STEP;
               nextState   = FETCH;
            end
         end
         DROP: begin
            if (redirect) nextFetchPc = redirectPc;
            if (imem_ack) nextState   = FETCH;
         end
         default: nextState = IDLE;
      endcase
   end

   // The request stays asserted through WAIT and DROP; reqAddr keeps the
   // address stable even after a redirect has moved fetchPc.
   always_comb begin
      imem_req  = 1'b0;
      imem_addr = '0;
      if (issue) begin
         imem_req  = 1'b1;
         imem_addr = fetchPc;
      end else if (state == WAIT || state == DROP) begin
         imem_req  = 1'b1;
         imem_addr = reqAddr;
      end
   end

   always_comb begin
      instr_valid = !fifoEmpty;
      instr_out   = NOP;
      instr_pc    = '0;
      if (!fifoEmpty) begin
         instr_out = headData[31:0];
         instr_pc  = headData[EW-1:32];
      end
      if (bypass) begin
         instr_valid = 1'b1;
         instr_out   = imem_rdata;
         instr_pc    = reqAddr;
      end
   end

endmodule
